// File: rtl/pipe_stage_buffer.sv
// Elastic pipeline stage register: valid/ready handshake with an optional 2-entry skid,
// flush that turns held entries into control-cleared bubbles, and a saturating stall counter.
module pipe_stage_buffer #(
  parameter int                 DATA_W    = 72,
  parameter int                 CTRL_W    = 3,
  parameter bit                 SKID      = 1'b1,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0,
  parameter int                 CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Keeps the payload bits, zeroes the control field at the top of the bundle.
  localparam logic [DATA_W-1:0] PAYLOAD_MASK = {{CTRL_W{1'b0}}, {(DATA_W-CTRL_W){1'b1}}};
  localparam logic [CNT_W-1:0]  CNT_MAX      = '1;

  logic              main_v_q, main_v_d;
  logic              skid_v_q, skid_v_d;
  logic [DATA_W-1:0] main_d_q, main_d_d;
  logic [DATA_W-1:0] skid_d_q, skid_d_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              accept, emit;

  generate
    if (SKID) begin : g_skid_ready
      // Only registered state and the synchronous reset feed in_ready; out_ready never does.
      assign in_ready = ~skid_v_q & ~reset;
    end else begin : g_single_ready
      assign in_ready = ~main_v_q | out_ready;
    end
  endgenerate

  always_comb begin
    accept   = in_valid & in_ready;
    emit     = main_v_q & out_ready;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_d_d = main_d_q;
    skid_d_d = skid_d_q;

    if (SKID) begin
      case ({main_v_q, skid_v_q})
        2'b00: begin
          if (accept) begin
            main_v_d = 1'b1;
            main_d_d = in_data;
          end
        end
        2'b10: begin
          if (accept && emit) begin
            main_d_d = in_data;
          end else if (accept) begin
            skid_v_d = 1'b1;
            skid_d_d = in_data;
          end else if (emit) begin
            main_v_d = 1'b0;
          end
        end
        2'b11: begin
          if (emit) begin
            main_d_d = skid_d_q;
            skid_v_d = 1'b0;
          end
        end
        default: begin
          skid_v_d = 1'b0;
        end
      endcase
    end else begin
      if (accept) begin
        main_v_d = 1'b1;
        main_d_d = in_data;
      end else if (emit) begin
        main_v_d = 1'b0;
      end
    end

    // A bundle accepted in the flush cycle is dropped; the held data keeps its payload.
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
      main_d_d = main_d_q & PAYLOAD_MASK;
    end

    stall_d = stall_q;
    if (main_v_q && !out_ready && stall_q != CNT_MAX) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_d_q <= RESET_VAL;
      skid_d_q <= RESET_VAL;
      stall_q  <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_d_q <= main_d_d;
      skid_d_q <= skid_d_d;
      stall_q  <= stall_d;
    end
  end

  assign out_valid = main_v_q;
  assign out_data  = main_v_q ? main_d_q : (main_d_q & PAYLOAD_MASK);
  assign stall_cnt = stall_q;

endmodule

// File: doc/pipe_stage_buffer.md
Name: pipe_stage_buffer

Overview:
- Parametrised, elastic successor to the fixed-width stage register between pipeline stages (MEM/WB and peers).
- Carries a DATA_W-bit packed stage bundle, with control fields in the top CTRL_W bits, under a valid/ready handshake.
- Optional 2-entry skid mode breaks the combinational ready path; a flush inserts bubbles with control bits cleared.
- A saturating stall counter supports performance debug.

Parameters:
DATA_W, 72, width of packed stage bundle
CTRL_W, 3, number of MSBs of the bundle that are control (write/read enables); forced to 0 in bubbles
SKID, 1, 1 = two-entry skid buffer (registered in_ready); 0 = single entry, combinational in_ready
RESET_VAL, 0, reset value of data registers (DATA_W bits)
CNT_W, 16, stall counter width

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
flush  in  1  squash all held entries (synchronous)
in_valid  in  1  upstream bundle valid
in_ready  out  1  buffer can accept
in_data  in  DATA_W  upstream bundle
out_valid  out  1  out_data holds a live bundle
out_ready  in  1  downstream accepts
out_data  out  DATA_W  bundle to next stage
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0

Behaviour:
- Accept: in_valid&in_ready at a rising edge. Emit: out_valid&out_ready at a rising edge.
- Storage: main entry (main_v, main_d) always drives the output; skid entry (skid_v, skid_d) exists only when SKID=1.
- out_valid = main_v.
- out_data = main_d when main_v; otherwise main_d with its top CTRL_W bits forced to 0, so bubbles never write memory or registers.
- Latency: an accepted bundle appears on out_data the cycle after acceptance; no combinational in->out path.
- Reset (priority over everything):
  - main_v=0, skid_v=0; main_d and skid_d = RESET_VAL; stall_cnt=0.
  - in_ready=0 while reset is high (SKID=1); after reset in_ready=1.
- Flush (priority below reset, above handshake):
  - Next cycle main_v=0 and skid_v=0; top CTRL_W bits of main_d cleared.
  - A bundle accepted in the flush cycle is discarded.
  - Downstream must not treat a same-cycle emit as committed.
  - stall_cnt is unaffected.
- SKID=1 state machine on (main_v, skid_v):
  - EMPTY (0,0): accept -> ONE with main<=in. in_ready=1.
  - ONE (1,0):
    - accept & emit -> ONE, main<=in.
    - accept & !emit -> FULL, skid<=in.
    - emit & !accept -> EMPTY.
    - neither -> hold.
    - in_ready=1.
  - FULL (1,1): emit -> ONE, main<=skid. No accept possible; in_ready=0.
  - in_ready = !skid_v, taken from a register only (no dependence on out_ready).
- SKID=0:
  - in_ready = !main_v | out_ready, combinational.
  - Accept -> main<=in, main_v=1. Emit without accept -> main_v=0.
- Ordering: strict FIFO; no bundle duplicated or dropped except by flush.
- stall_cnt: +1 each cycle with out_valid & !out_ready; saturates at 2^CNT_W-1; cleared only by reset.
- Data registers load only on accept or skid->main move; they hold otherwise, giving no spurious toggling.

Test Plan:
1. Reset held 2 cycles with in_valid=1 and in_data=0xA5 pattern -> out_valid=0, out_data=RESET_VAL, stall_cnt=0, in_ready=0 during reset and 1 the cycle after.
2. Streaming, out_ready=1, bundles D0..D3 (0x01..0x04) on 4 consecutive cycles -> out_data = D0..D3 on cycles 1..4, out_valid high 4 cycles, in_ready stays 1.
3. Backpressure (SKID=1), out_ready=0 from cycle 1, D0, D1, D2 offered -> D0 in main, D1 in skid, in_ready=0 from cycle 2, D2 held upstream. Release out_ready -> D0, D1, D2 emerge in order, stall_cnt = number of stalled cycles.
4. Flush while FULL, with control bits set (top bits 3'b111) -> next cycle out_valid=0, out_data[DATA_W-1:DATA_W-CTRL_W]=0, in_ready=1; the bundle offered in the flush cycle never appears.
5. SKID=0 build, out_ready toggled 1,0,1 with continuous input -> in_ready follows !main_v|out_ready combinationally; no loss or duplication (scoreboard).
6. CNT_W=4, out_ready=0 for 20 cycles with main_v=1 -> stall_cnt saturates at 15 and holds; flush does not clear it; reset does.
